// File: rtl/pipe_ctrl.sv
// Pipeline hazard and trap controller: stall/flush generation, jump redirect,
// and a small sequencer that performs the CSR writes for ecall, timer irq and mret.
module pipe_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000_0007
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_exe_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] exception_i,
  input  logic [31:0] inst_addr_i,
  input  logic        irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic [4:0]  stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_addr_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        busy_o
);

  // state    | meaning
  // IDLE     | normal flow; jumps redirect, traps may be accepted
  // W_MEPC   | write mepc with the trapping PC
  // W_MCAUSE | write mcause
  // W_MSTAT  | write mstatus on trap entry (MPIE<=MIE, MIE<=0, MPP<=M)
  // M_MSTAT  | write mstatus on mret (MIE<=MPIE, MPIE<=1)
  // REDIR    | redirect PC to mtvec (trap) or mepc (mret)
  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTAT, M_MSTAT, REDIR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, cause_q;
  logic        mret_q;

  logic is_mret, is_ecall, take_irq, accept;

  assign is_mret  = exception_i[0];
  assign is_ecall = exception_i[1];
  assign take_irq = irq_i & csr_mstatus_i[3];
  assign accept   = (state == IDLE) & ~jump_req_i & ~stallreq_exe_i &
                    (is_mret | is_ecall | take_irq);

  logic unused_bits;
  assign unused_bits = ^{exception_i[31:2], csr_mtvec_i[1:0], csr_mepc_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pc_q    <= inst_addr_i;
        cause_q <= is_ecall ? ECALL_CAUSE : IRQ_CAUSE;
        mret_q  <= is_mret;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = is_mret ? M_MSTAT : W_MEPC;
      W_MEPC:   state_nxt = W_MCAUSE;
      W_MCAUSE: state_nxt = W_MSTAT;
      W_MSTAT:  state_nxt = REDIR;
      M_MSTAT:  state_nxt = REDIR;
      REDIR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  logic [31:0] mstat_trap, mstat_mret;

  always_comb begin
    mstat_trap        = csr_mstatus_i;
    mstat_trap[7]     = csr_mstatus_i[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = 2'b11;
    mstat_mret        = csr_mstatus_i;
    mstat_mret[3]     = csr_mstatus_i[7];
    mstat_mret[7]     = 1'b1;
  end

  always_comb begin
    stall_o         = 5'b00000;
    flush_o         = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;
    csr_we_o        = 1'b0;
    csr_waddr_o     = '0;
    csr_wdata_o     = '0;
    busy_o          = 1'b0;
    if (!rst_i) begin
      busy_o = (state != IDLE);
      // An accepted trap takes over the ID stall: the stalled instruction is flushed.
      if (busy_o)                          stall_o = 5'b00001;
      else if (stallreq_exe_i)             stall_o = 5'b01111;
      else if (stallreq_id_i && !accept)   stall_o = 5'b00111;
      case (state)
        IDLE: begin
          if (jump_req_i) begin
            redirect_o      = 1'b1;
            redirect_addr_o = jump_addr_i;
            flush_o         = 1'b1;
          end else if (accept) begin
            flush_o = 1'b1;
          end
        end
        W_MEPC: begin
          flush_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_waddr_o = 12'h341;
          csr_wdata_o = pc_q;
        end
        W_MCAUSE: begin
          flush_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_waddr_o = 12'h342;
          csr_wdata_o = cause_q;
        end
        W_MSTAT: begin
          flush_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_waddr_o = 12'h300;
          csr_wdata_o = mstat_trap;
        end
        M_MSTAT: begin
          flush_o     = 1'b1;
          csr_we_o    = 1'b1;
          csr_waddr_o = 12'h300;
          csr_wdata_o = mstat_mret;
        end
        REDIR: begin
          flush_o         = 1'b1;
          redirect_o      = 1'b1;
          redirect_addr_o = mret_q ? {csr_mepc_i[31:2], 2'b00}
                                   : {csr_mtvec_i[31:2], 2'b00};
        end
        default: flush_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: ecall, mret, gated irq, jump/stall interplay, mid-sequence reset.
module tb_pipe_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stallreq_id_i, stallreq_exe_i, jump_req_i, irq_i;
  logic [31:0] jump_addr_i, exception_i, inst_addr_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic [4:0]  stall_o;
  logic        flush_o, redirect_o, csr_we_o, busy_o;
  logic [31:0] redirect_addr_o, csr_wdata_o;
  logic [11:0] csr_waddr_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .stallreq_id_i(stallreq_id_i), .stallreq_exe_i(stallreq_exe_i),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .exception_i(exception_i), .inst_addr_i(inst_addr_i), .irq_i(irq_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1ns later, before the next rising edge.
  task automatic step;
    @(negedge clk_i);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check_csr(input string tag, input logic we, input logic [11:0] a,
                           input logic [31:0] d);
    check({tag, "_we"}, {31'd0, csr_we_o}, {31'd0, we});
    check({tag, "_addr"}, {20'd0, csr_waddr_o}, {20'd0, a});
    check({tag, "_data"}, csr_wdata_o, d);
  endtask

  initial begin
    rst_i = 1'b1; stallreq_id_i = 1'b0; stallreq_exe_i = 1'b1; jump_req_i = 1'b1;
    irq_i = 1'b0; jump_addr_i = 32'h40; exception_i = 32'd0; inst_addr_i = 32'd0;
    csr_mtvec_i = 32'h205; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h8;

    // reset: every output zero, even with requests asserted
    step; settle;
    check("rst_stall", {27'd0, stall_o}, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_redir", {31'd0, redirect_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check_csr("rst", 1'b0, 12'h0, 32'd0);

    // stall priorities
    step; rst_i = 1'b0; jump_req_i = 1'b0; stallreq_exe_i = 1'b1; stallreq_id_i = 1'b1; settle;
    check("stall_exe", {27'd0, stall_o}, 32'h0F);
    step; stallreq_exe_i = 1'b0; settle;
    check("stall_id", {27'd0, stall_o}, 32'h07);
    step; stallreq_id_i = 1'b0; settle;
    check("stall_none", {27'd0, stall_o}, 32'h00);

    // ecall at 0x100
    step; exception_i = 32'h2; inst_addr_i = 32'h100; settle;
    check("ec_acc_flush", {31'd0, flush_o}, 32'd1);
    check("ec_acc_busy", {31'd0, busy_o}, 32'd0);
    step; exception_i = 32'd0; inst_addr_i = 32'h999; settle;
    check_csr("ec_mepc", 1'b1, 12'h341, 32'h100);
    check("ec_busy", {31'd0, busy_o}, 32'd1);
    check("ec_busy_stall", {27'd0, stall_o}, 32'h01);
    step; jump_req_i = 1'b1; jump_addr_i = 32'h500; settle;
    check_csr("ec_mcause", 1'b1, 12'h342, 32'd11);
    check("ec_jump_ignored", {31'd0, redirect_o}, 32'd0);
    step; jump_req_i = 1'b0; settle;
    check_csr("ec_mstat", 1'b1, 12'h300, 32'h1880);
    check("ec_flush_busy", {31'd0, flush_o}, 32'd1);
    step; settle;
    check("ec_redir", {31'd0, redirect_o}, 32'd1);
    check("ec_redir_addr", redirect_addr_o, 32'h204);
    check_csr("ec_redir_nocsr", 1'b0, 12'h0, 32'd0);
    step; settle;
    check("ec_idle", {31'd0, busy_o}, 32'd0);
    check("ec_idle_redir", {31'd0, redirect_o}, 32'd0);

    // mret
    step; exception_i = 32'h1; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h1880; settle;
    check("mr_acc_flush", {31'd0, flush_o}, 32'd1);
    step; exception_i = 32'd0; settle;
    check_csr("mr_mstat", 1'b1, 12'h300, 32'h1888);
    step; settle;
    check("mr_redir", {31'd0, redirect_o}, 32'd1);
    check("mr_redir_addr", redirect_addr_o, 32'h104);
    step; settle;
    check("mr_done", {31'd0, busy_o}, 32'd0);

    // irq masked by MIE=0, then accepted over an ID stall
    step; irq_i = 1'b1; csr_mstatus_i = 32'h0; stallreq_id_i = 1'b1; inst_addr_i = 32'h80; settle;
    check("irq_mask_flush", {31'd0, flush_o}, 32'd0);
    check("irq_mask_stall", {27'd0, stall_o}, 32'h07);
    step; settle;
    check("irq_mask_busy", {31'd0, busy_o}, 32'd0);
    csr_mstatus_i = 32'h8; settle;
    check("irq_acc_flush", {31'd0, flush_o}, 32'd1);
    step; settle;
    check_csr("irq_mepc", 1'b1, 12'h341, 32'h80);
    step; settle;
    check_csr("irq_mcause", 1'b1, 12'h342, 32'h8000_0007);
    step; settle;
    check_csr("irq_mstat", 1'b1, 12'h300, 32'h1880);
    step; irq_i = 1'b0; stallreq_id_i = 1'b0; settle;
    check("irq_redir_addr", redirect_addr_o, 32'h204);
    step; settle;
    check("irq_done", {31'd0, busy_o}, 32'd0);

    // ecall together with a jump: only the jump takes effect
    step; exception_i = 32'h2; jump_req_i = 1'b1; jump_addr_i = 32'h400; settle;
    check("ej_redir", {31'd0, redirect_o}, 32'd1);
    check("ej_addr", redirect_addr_o, 32'h400);
    check("ej_flush", {31'd0, flush_o}, 32'd1);
    check_csr("ej_nocsr", 1'b0, 12'h0, 32'd0);
    step; exception_i = 32'd0; jump_req_i = 1'b0; settle;
    check("ej_notbusy", {31'd0, busy_o}, 32'd0);

    // ecall deferred by an EXE stall, then reset in W_MCAUSE
    step; exception_i = 32'h2; inst_addr_i = 32'h200; stallreq_exe_i = 1'b1; settle;
    check("es_stall", {27'd0, stall_o}, 32'h0F);
    check("es_noflush", {31'd0, flush_o}, 32'd0);
    step; settle;
    check("es_deferred", {31'd0, busy_o}, 32'd0);
    stallreq_exe_i = 1'b0; settle;
    check("es_accept_flush", {31'd0, flush_o}, 32'd1);
    step; exception_i = 32'd0; settle;
    check_csr("es_mepc", 1'b1, 12'h341, 32'h200);
    step; rst_i = 1'b1; settle;
    check("rs_busy", {31'd0, busy_o}, 32'd0);
    check("rs_flush", {31'd0, flush_o}, 32'd0);
    check("rs_stall", {27'd0, stall_o}, 32'd0);
    check_csr("rs_csr", 1'b0, 12'h0, 32'd0);
    step; rst_i = 1'b0; settle;
    check("rs_idle", {31'd0, busy_o}, 32'd0);
    check("rs_noredir", {31'd0, redirect_o}, 32'd0);
    check_csr("rs_after", 1'b0, 12'h0, 32'd0);
    step; settle;
    check("rs_still_idle", {31'd0, busy_o}, 32'd0);
    check("rs_no_late_redir", {31'd0, redirect_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
